// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial bus master: FSM states,
// peripheral word addresses, status bit positions and the per-state bus drive.
package fact_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_N   = 3'd1,
        WR_GO  = 3'd2,
        POLL   = 3'd3,
        RD_RES = 3'd4,
        RESP   = 3'd5
    } state_e;

    localparam logic [1:0] ADDR_N      = 2'b00;
    localparam logic [1:0] ADDR_GO     = 2'b01;
    localparam logic [1:0] ADDR_STATUS = 2'b10;
    localparam logic [1:0] ADDR_RESULT = 2'b11;

    localparam int unsigned ST_DONE = 0;
    localparam int unsigned ST_ERR  = 1;

    typedef struct packed {
        logic [1:0] a;
        logic       we;
        logic [3:0] wd;
    } bus_ctrl_t;

    // Bus drive for the cycle spent in state st; n is the operand for WR_N.
    function automatic bus_ctrl_t bus_ctrl(input state_e st, input logic [3:0] n);
        bus_ctrl_t c;
        c.a  = ADDR_N;
        c.we = 1'b0;
        c.wd = 4'h0;
        case (st)
            WR_N: begin
                c.a  = ADDR_N;
                c.we = 1'b1;
                c.wd = n;
            end
            WR_GO: begin
                c.a  = ADDR_GO;
                c.we = 1'b1;
                c.wd = 4'b0001;
            end
            POLL:    c.a = ADDR_STATUS;
            RD_RES:  c.a = ADDR_RESULT;
            default: c.we = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fact_poll_timer.sv
// Status-poll watchdog for fact_bus_master; only instantiated when the
// FACT_MASTER_TIMEOUT_EN build option is defined.
module fact_poll_timer #(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

    logic [CNT_W-1:0] count_r;

    // Expiry is flagged on the enabled cycle whose increment would reach POLL_MAX.
    assign expired = enable && (count_r == CNT_W'(POLL_MAX - 1));

    // Poll counter: cleared on launch, saturates at POLL_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_W'(POLL_MAX))) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fact_bus_master.sv
// Request/response front end that drives a memory-mapped factorial peripheral.
// Optional poll timeout is enabled by defining FACT_MASTER_TIMEOUT_EN.
module fact_bus_master
    import fact_pkg::*;
#(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_n,
    output logic        req_ready,
    output logic [1:0]  bus_a,
    output logic        bus_we,
    output logic [3:0]  bus_wd,
    input  logic [31:0] bus_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_err,
    output logic        resp_timeout
);

    state_e    state_r;
    state_e    state_next_s;
    bus_ctrl_t bus_next_s;
    logic      done_s;
    logic      err_s;
    logic      expired_s;
    logic      poll_fail_s;
    logic      timeout_s;
    logic      load_res_s;

    assign done_s = bus_rd[ST_DONE];
    assign err_s  = bus_rd[ST_ERR];

`ifdef FACT_MASTER_TIMEOUT_EN
    logic poll_en_s;
    logic poll_clr_s;

    assign poll_en_s  = (state_r == POLL) && !done_s && !err_s;
    assign poll_clr_s = (state_r == WR_GO);

    fact_poll_timer #(
        .POLL_MAX (POLL_MAX)
    ) u_poll_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (poll_clr_s),
        .enable  (poll_en_s),
        .expired (expired_s)
    );
`else
    // Parameter kept so both builds share one instantiation interface.
    localparam int unsigned POLL_MAX_UNUSED = POLL_MAX;
    assign expired_s = 1'b0;
`endif

    // Next-state selection; error outranks done, done outranks timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_next_s = WR_N;
                else           state_next_s = IDLE;
            end
            WR_N:   state_next_s = WR_GO;
            WR_GO:  state_next_s = POLL;
            POLL: begin
                if (err_s)          state_next_s = RESP;
                else if (done_s)    state_next_s = RD_RES;
                else if (expired_s) state_next_s = RESP;
                else                state_next_s = POLL;
            end
            RD_RES: state_next_s = RESP;
            RESP: begin
                if (resp_ready) state_next_s = IDLE;
                else            state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Response outcome strobes and the bus drive for the upcoming state.
    always_comb begin
        poll_fail_s = (state_r == POLL) && err_s;
        timeout_s   = (state_r == POLL) && !err_s && !done_s && expired_s;
        load_res_s  = (state_r == RD_RES);
        bus_next_s  = bus_ctrl(state_next_s, req_n);
    end

    // State, bus and response registers; bus_wd latches req_n on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            req_ready    <= 1'b1;
            bus_a        <= 2'b00;
            bus_we       <= 1'b0;
            bus_wd       <= 4'h0;
            resp_valid   <= 1'b0;
            resp_result  <= 32'h0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            req_ready  <= (state_next_s == IDLE);
            resp_valid <= (state_next_s == RESP);
            bus_a      <= bus_next_s.a;
            bus_we     <= bus_next_s.we;
            bus_wd     <= bus_next_s.wd;
            if (load_res_s) begin
                resp_result  <= bus_rd;
                resp_err     <= 1'b0;
                resp_timeout <= 1'b0;
            end else if (poll_fail_s || timeout_s) begin
                resp_result  <= 32'h0;
                resp_err     <= 1'b1;
                resp_timeout <= timeout_s;
            end else begin
                resp_result  <= resp_result;
                resp_err     <= resp_err;
                resp_timeout <= resp_timeout;
            end
        end
    end

endmodule

// File: tb/tb_fact_bus_master.sv
// Directed self-checking bench for fact_bus_master with a behavioural
// factorial peripheral; timeout cases run when FACT_MASTER_TIMEOUT_EN is defined.
module tb_fact_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_n = 4'h0;
    logic        req_ready;
    logic [1:0]  bus_a;
    logic        bus_we;
    logic [3:0]  bus_wd;
    logic [31:0] bus_rd;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        resp_err;
    logic        resp_timeout;

    int n_cmp = 0;
    int n_mis = 0;

    fact_bus_master #(.POLL_MAX(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_n        (req_n),
        .req_ready    (req_ready),
        .bus_a        (bus_a),
        .bus_we       (bus_we),
        .bus_wd       (bus_wd),
        .bus_rd       (bus_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout)
    );

    always #5 clk = ~clk;

    // Peripheral model state
    int          model_delay = 10;
    bit          m_hang = 1'b0;
    logic [3:0]  m_n = 4'h0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_res = 32'h0;
    int          m_cnt = 0;
    bit          m_busy = 1'b0;

    // Bus monitor
    logic [5:0]  wr_log[$];
    int          rd_cnt = 0;
    int          poll_cnt = 0;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    always_comb begin
        case (bus_a)
            2'b00:   bus_rd = {28'h0, m_n};
            2'b10:   bus_rd = {30'h0, m_err, m_done};
            2'b11:   bus_rd = m_res;
            default: bus_rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (bus_we && bus_a == 2'b01 && bus_wd[0]) begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (!m_hang) begin
                if (model_delay == 0) begin
                    if (m_n > 4'd12) m_err <= 1'b1;
                    else begin m_done <= 1'b1; m_res <= fact(m_n); end
                end else begin
                    m_cnt  <= model_delay;
                    m_busy <= 1'b1;
                end
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                if (m_n > 4'd12) m_err <= 1'b1;
                else begin m_done <= 1'b1; m_res <= fact(m_n); end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (!rst && bus_we && bus_a == 2'b00) m_n <= bus_wd;
    end

    always @(posedge clk) begin
        if (bus_we) wr_log.push_back({bus_a, bus_wd});
        if (!bus_we && bus_a == 2'b11) rd_cnt++;
        if (!bus_we && bus_a == 2'b10) poll_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int wr_base, rd_base, poll_base, lat;

    // Issue one request and wait (bounded) for resp_valid; lat counts cycles.
    task automatic run_req(input logic [3:0] n);
        bit ok = 1'b0;
        @(negedge clk);
        wr_base   = wr_log.size();
        rd_base   = rd_cnt;
        poll_base = poll_cnt;
        req_valid = 1'b1;
        req_n     = n;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        if (!ok) check("resp_wait", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("hs_valid_low", 32'(resp_valid), 32'd0);
        check("hs_ready_high", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int wr_hold;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_a", 32'(bus_a), 32'd0);
        check("rst_bus_wd", 32'(bus_wd), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        rst = 1'b0;

        // 0! with immediate done: minimum latency
        model_delay = 0;
        run_req(4'd0);
        check("n0_latency", 32'(lat), 32'd5);
        check("n0_result", resp_result, 32'd1);
        check("n0_err", 32'(resp_err), 32'd0);
        handshake();

        // 5! with done after 10 cycles
        model_delay = 10;
        run_req(4'd5);
        check("n5_result", resp_result, 32'd120);
        check("n5_err", 32'(resp_err), 32'd0);
        check("n5_timeout", 32'(resp_timeout), 32'd0);
        check("n5_wr_count", 32'(wr_log.size() - wr_base), 32'd2);
        check("n5_wr0", 32'(wr_log[wr_base]), 32'({2'b00, 4'd5}));
        check("n5_wr1", 32'(wr_log[wr_base + 1]), 32'({2'b01, 4'd1}));
        check("n5_rd_res", 32'(rd_cnt - rd_base), 32'd1);
        check("n5_no_req_ready", 32'(req_ready), 32'd0);

        // Hold response 20 cycles with a competing request asserted
        held      = resp_result;
        wr_hold   = wr_log.size();
        req_valid = 1'b1;
        req_n     = 4'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_result", resp_result, held);
        end
        check("hold_no_writes", 32'(wr_log.size()), 32'(wr_hold));
        req_valid = 1'b0;
        handshake();

        // 13! overflows: peripheral error, no result read
        model_delay = 3;
        run_req(4'd13);
        check("n13_err", 32'(resp_err), 32'd1);
        check("n13_result", resp_result, 32'd0);
        check("n13_timeout", 32'(resp_timeout), 32'd0);
        check("n13_rd_res", 32'(rd_cnt - rd_base), 32'd0);
        handshake();

        // Reset while polling a peripheral that never finishes
        m_hang = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 4'd9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a == 2'b10 && !bus_we) begin seen = 1'b1; break; end
        end
        check("poll_reached", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_bus_we", 32'(bus_we), 32'd0);
        check("mid_rst_bus_a", 32'(bus_a), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        m_hang = 1'b0;
        model_delay = 2;
        run_req(4'd3);
        check("n3_result", resp_result, 32'd6);
        check("n3_err", 32'(resp_err), 32'd0);
        handshake();

`ifdef FACT_MASTER_TIMEOUT_EN
        m_hang = 1'b1;
        run_req(4'd4);
        check("to_poll_cycles", 32'(poll_cnt - poll_base), 32'd8);
        check("to_err", 32'(resp_err), 32'd1);
        check("to_timeout", 32'(resp_timeout), 32'd1);
        check("to_result", resp_result, 32'd0);
        handshake();
        m_hang = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
